branch_predictor: RTL

- Dynamic branch predictor and redirect controller for the 5-stage RISC-V pipeline.
- IF side: combinational lookup in a direct-mapped BTB plus 2-bit bimodal counter table, producing next-PC prediction for `if_pc`.
- EX side: compares the branch-resolution result (taken flag and target from the EX branch logic) with the prediction carried down the pipe, raises redirect/flush on mispredict, and trains the tables on the clock edge.
- Keeps saturating performance counters.

---
 rtl/branch_predictor_if.sv | 34 +++
 rtl/branch_predictor.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX-side resolution bundle of the branch predictor.
// The pipeline drives through master and the predictor sits behind slave.
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_taken,
           ex_target, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, redirect, redirect_pc, flush,
           branch_count, mispredict_count
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_taken,
           ex_target, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, redirect, redirect_pc, flush,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit bimodal counters: zero-latency IF prediction,
// same-cycle EX mispredict redirect, table training and saturating statistics.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 4,
  parameter logic [1:0]  CTR_INIT   = 2'b01
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bp
);

  localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;
  localparam int unsigned TAG_LSB  = INDEX_BITS + 2;

  logic                entry_valid  [ENTRIES];
  logic [TAG_BITS-1:0] entry_tag    [ENTRIES];
  logic [31:0]         entry_target [ENTRIES];
  logic [1:0]          entry_ctr    [ENTRIES];

  logic [INDEX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0]   if_tag;
  logic                  if_hit;
  logic                  pred_taken_c;

  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0]   ex_tag;
  logic                  ex_hit;
  logic                  ex_jump;
  logic                  ex_branch;
  logic                  ex_control;
  logic [31:0]           ex_fallthrough;
  logic [1:0]            ctr_inc;
  logic [1:0]            ctr_dec;

  logic                  redirect_c;
  logic [31:0]           redirect_pc_c;

  logic [31:0]           branch_count_q;
  logic [31:0]           mispredict_count_q;

  logic                  unused_pc_bits;

  assign unused_pc_bits = ^{bp.if_pc[1:0], bp.ex_pc[1:0]};

  // IF lookup: reads see the pre-edge table, so an EX write this cycle is invisible here
  assign if_idx = bp.if_pc[TAG_LSB-1:2];
  assign if_tag = bp.if_pc[31:TAG_LSB];

  always_comb begin
    if_hit       = entry_valid[if_idx] && (entry_tag[if_idx] == if_tag);
    pred_taken_c = rst_n && if_hit && entry_ctr[if_idx][1];
  end

  assign bp.pred_taken  = pred_taken_c;
  assign bp.pred_target = pred_taken_c ? entry_target[if_idx] : bp.if_pc + 32'd4;

  // EX classification; a branch that is also flagged as a jump behaves as a jump
  assign ex_idx         = bp.ex_pc[TAG_LSB-1:2];
  assign ex_tag         = bp.ex_pc[31:TAG_LSB];
  assign ex_jump        = bp.ex_is_jump;
  assign ex_branch      = bp.ex_is_branch && !bp.ex_is_jump;
  assign ex_control     = bp.ex_is_branch || bp.ex_is_jump;
  assign ex_fallthrough = bp.ex_pc + 32'd4;

  always_comb begin
    ex_hit  = entry_valid[ex_idx] && (entry_tag[ex_idx] == ex_tag);
    ctr_inc = (entry_ctr[ex_idx] == 2'b11) ? 2'b11 : entry_ctr[ex_idx] + 2'd1;
    ctr_dec = (entry_ctr[ex_idx] == 2'b00) ? 2'b00 : entry_ctr[ex_idx] - 2'd1;
  end

  // Mispredict detection against the prediction carried down from IF
  always_comb begin
    redirect_c    = 1'b0;
    redirect_pc_c = 32'd0;
    if (rst_n && bp.ex_valid) begin
      if (ex_control && bp.ex_taken &&
          (!bp.ex_pred_taken || (bp.ex_pred_target != bp.ex_target))) begin
        redirect_c    = 1'b1;
        redirect_pc_c = bp.ex_target;
      end else if (ex_branch && !bp.ex_taken && bp.ex_pred_taken) begin
        redirect_c    = 1'b1;
        redirect_pc_c = ex_fallthrough;
      end else if (!ex_control && bp.ex_pred_taken) begin
        redirect_c    = 1'b1;
        redirect_pc_c = ex_fallthrough;
      end
    end
  end

  assign bp.redirect    = redirect_c;
  assign bp.redirect_pc = redirect_pc_c;
  assign bp.flush       = redirect_c;

  // Table training from the resolved EX instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entry_valid[i]  <= 1'b0;
        entry_tag[i]    <= '0;
        entry_target[i] <= 32'd0;
        entry_ctr[i]    <= CTR_INIT;
      end
    end else if (bp.ex_valid) begin
      if (ex_jump) begin
        entry_valid[ex_idx]  <= 1'b1;
        entry_tag[ex_idx]    <= ex_tag;
        entry_target[ex_idx] <= bp.ex_target;
        entry_ctr[ex_idx]    <= 2'b11;
      end else if (ex_branch) begin
        if (bp.ex_taken) begin
          entry_valid[ex_idx]  <= 1'b1;
          entry_tag[ex_idx]    <= ex_tag;
          entry_target[ex_idx] <= bp.ex_target;
          entry_ctr[ex_idx]    <= ex_hit ? ctr_inc : 2'b10;
        end else if (ex_hit) begin
          entry_ctr[ex_idx] <= ctr_dec;
        end
      end else if (bp.ex_pred_taken) begin
        entry_valid[ex_idx] <= 1'b0;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_count_q     <= 32'd0;
      mispredict_count_q <= 32'd0;
    end else begin
      if (bp.ex_valid && ex_control && (branch_count_q != 32'hFFFF_FFFF)) begin
        branch_count_q <= branch_count_q + 32'd1;
      end
      if (redirect_c && (mispredict_count_q != 32'hFFFF_FFFF)) begin
        mispredict_count_q <= mispredict_count_q + 32'd1;
      end
    end
  end

  assign bp.branch_count     = branch_count_q;
  assign bp.mispredict_count = mispredict_count_q;

endmodule
